jt08_adpcm_rom_arb: RTL and testbench

//  Shares one external sample-ROM/SDRAM read port between the ADPCM-A driver (6-ch, time-multiplexed,

---
 rtl/jt08_adpcm_pkg.sv | 14 +
 rtl/jt08_adpcm_rom_arb.sv | 146 ++++++++++++++
 tb/tb_jt08_adpcm_rom_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt08_adpcm_pkg.sv
// Shared definitions for the ADPCM sample-ROM arbiter.
//   arb_state_e : arbiter FSM states (idle, ADPCM-A fetch, ADPCM-B fetch)
//   DefaultAw   : default memory byte-address width
package jt08_adpcm_pkg;

   localparam int unsigned DefaultAw = 24;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAWait = 2'd1,
      StBWait = 2'd2
   } arb_state_e;

endpackage

// File: rtl/jt08_adpcm_rom_arb.sv
// Shares one memory read port between the ADPCM-A driver and the ADPCM-B streamer.
// ADPCM-A has strict priority but never preempts a B transfer that is already in flight.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   i_a_addr/i_a_bank         ADPCM-A byte address, full address = {bank,addr}
//   i_a_roe_n                 ADPCM-A output enable; a falling edge is a new request
//   o_a_data                  last byte fetched for ADPCM-A
//   i_b_addr/i_b_req          ADPCM-B address and request level
//   o_b_ack/o_b_data          ADPCM-B one-cycle ack with its byte
//   o_mem_addr/o_mem_req      memory request, held until i_mem_ack
//   i_mem_ack/i_mem_data      memory ack pulse with read data
//   o_a_late                  saturating count of ADPCM-A requests that overran their slot
module jt08_adpcm_rom_arb
   import jt08_adpcm_pkg::*;
#(
   parameter int unsigned     AW     = DefaultAw,
   parameter logic [AW-1:0]   A_BASE = '0,
   parameter logic [AW-1:0]   B_BASE = '0,
   parameter int unsigned     LATE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [19:0]       i_a_addr,
   input  logic [3:0]        i_a_bank,
   input  logic              i_a_roe_n,
   output logic [7:0]        o_a_data,
   input  logic [AW-1:0]     i_b_addr,
   input  logic              i_b_req,
   output logic              o_b_ack,
   output logic [7:0]        o_b_data,
   output logic [AW-1:0]     o_mem_addr,
   output logic              o_mem_req,
   input  logic              i_mem_ack,
   input  logic [7:0]        i_mem_data,
   output logic [LATE_W-1:0] o_a_late
);

   arb_state_e        r_state;
   logic              r_roe_prev;
   logic              r_a_pend;
   logic [AW-1:0]     r_a_addr;
   logic [7:0]        r_a_data;
   logic              r_b_ack;
   logic [7:0]        r_b_data;
   logic [AW-1:0]     r_mem_addr;
   logic              r_mem_req;
   logic [LATE_W-1:0] r_a_late;

   logic              w_a_fall;
   logic [AW-1:0]     w_a_req_addr;
   logic [AW-1:0]     w_a_issue_addr;
   logic [AW-1:0]     w_b_addr;
   logic              w_b_elig;
   logic              w_a_late;
   logic              w_a_issue;

   assign w_a_fall     = r_roe_prev & ~i_a_roe_n;
   // Address sums wrap modulo 2^AW.
   assign w_a_req_addr = A_BASE + AW'({i_a_bank, i_a_addr});
   assign w_b_addr     = B_BASE + i_b_addr;

   // The cycle right after b_ack is excluded so a b_req that drops one cycle late is not re-served.
   assign w_b_elig = i_b_req & (r_state != StBWait) & ~r_b_ack;

   // Overrun: a new A edge while an A fetch is outstanding or an A request is still queued.
   assign w_a_late = w_a_fall & ((r_state == StAWait) | r_a_pend);

   assign w_a_issue = (r_state == StIdle) & r_a_pend;

   // A queued request overwritten in its issue cycle sends the newer address.
   assign w_a_issue_addr = w_a_fall ? w_a_req_addr : r_a_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_roe_prev <= 1'b1;
         r_a_pend   <= 1'b0;
         r_a_addr   <= '0;
         r_a_data   <= '0;
         r_b_ack    <= 1'b0;
         r_b_data   <= '0;
         r_mem_addr <= '0;
         r_mem_req  <= 1'b0;
         r_a_late   <= '0;
      end else begin
         r_roe_prev <= i_a_roe_n;
         r_b_ack    <= 1'b0;

         if (w_a_fall) begin
            r_a_addr <= w_a_req_addr;
         end

         if (w_a_issue) begin
            r_a_pend <= 1'b0;
         end else if (w_a_fall) begin
            r_a_pend <= 1'b1;
         end

         if (w_a_late && (r_a_late != {LATE_W{1'b1}})) begin
            r_a_late <= r_a_late + LATE_W'(1);
         end

         case (r_state)
            StIdle: begin
               if (r_a_pend) begin
                  r_state    <= StAWait;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_a_issue_addr;
               end else if (w_b_elig && !w_a_fall) begin
                  // A fresh A edge this cycle becomes pending next cycle and must win over B.
                  r_state    <= StBWait;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_b_addr;
               end
            end
            StAWait: begin
               if (i_mem_ack) begin
                  r_a_data  <= i_mem_data;
                  r_mem_req <= 1'b0;
                  r_state   <= StIdle;
               end
            end
            StBWait: begin
               if (i_mem_ack) begin
                  r_b_data  <= i_mem_data;
                  r_b_ack   <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_state   <= StIdle;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign o_a_data   = r_a_data;
   assign o_b_ack    = r_b_ack;
   assign o_b_data   = r_b_data;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_req  = r_mem_req;
   assign o_a_late   = r_a_late;

endmodule

// File: tb/tb_jt08_adpcm_rom_arb.sv
// Directed bench for jt08_adpcm_rom_arb with a small memory responder.
module tb_jt08_adpcm_rom_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] a_addr = '0;
   logic [3:0]  a_bank = '0;
   logic        a_roe_n = 1'b1;
   logic [7:0]  a_data;
   logic [23:0] b_addr = '0;
   logic        b_req = 1'b0;
   logic        b_ack;
   logic [7:0]  b_data;
   logic [23:0] mem_addr;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_data = '0;
   logic [7:0]  a_late;

   always #5 clk = ~clk;

   jt08_adpcm_rom_arb dut (
      .clk        (clk),
      .rst        (rst),
      .i_a_addr   (a_addr),
      .i_a_bank   (a_bank),
      .i_a_roe_n  (a_roe_n),
      .o_a_data   (a_data),
      .i_b_addr   (b_addr),
      .i_b_req    (b_req),
      .o_b_ack    (b_ack),
      .o_b_data   (b_data),
      .o_mem_addr (mem_addr),
      .o_mem_req  (mem_req),
      .i_mem_ack  (mem_ack),
      .i_mem_data (mem_data),
      .o_a_late   (a_late)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          b_ack_cnt = 0;
   logic [7:0]  b_last = '0;
   bit          mem_en = 1'b1;
   int          mem_delay = 3;
   logic [7:0]  mem_bytes[$];
   logic [23:0] mem_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: acks mem_delay cycles after seeing mem_req, bytes from mem_bytes.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_en) begin
            mem_ack = 1'b0;
            if (mem_req) begin
               if (cnt == mem_delay) begin
                  mem_ack  = 1'b1;
                  mem_data = (mem_bytes.size() > 0) ? mem_bytes.pop_front() : 8'hEE;
                  mem_log.push_back(mem_addr);
                  cnt = 0;
               end else begin
                  cnt++;
               end
            end else begin
               cnt = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (b_ack) begin
            b_ack_cnt++;
            b_last = b_data;
         end
      end
   end

   task automatic wait_b_ack(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (b_ack) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_mem_idle(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (!mem_req) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0;
      bit seen;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_a_data", 32'(a_data), 32'd0);
      check("rst_b_ack", 32'(b_ack), 32'd0);
      check("rst_b_data", 32'(b_data), 32'd0);
      check("rst_a_late", 32'(a_late), 32'd0);

      // 1: single A fetch
      a_bank = 4'h1;
      a_addr = 20'h00010;
      mem_bytes.push_back(8'hA5);
      a_roe_n = 1'b0;
      tick();
      check("t1_req_early", 32'(mem_req), 32'd0);
      tick();
      check("t1_req", 32'(mem_req), 32'd1);
      check("t1_addr", 32'(mem_addr), 32'h100010);
      wait_mem_idle("t1_wait");
      check("t1_a_data", 32'(a_data), 32'hA5);
      a_roe_n = 1'b1;
      tick();

      // 2: single B fetch, b_req released one cycle after b_ack
      cnt0 = b_ack_cnt;
      mem_bytes.push_back(8'h3C);
      b_addr = 24'h012345;
      b_req = 1'b1;
      wait_b_ack("t2_wait");
      check("t2_b_data", 32'(b_data), 32'h3C);
      check("t2_addr", 32'(mem_addr), 32'h012345);
      tick();
      b_req = 1'b0;
      tick();
      check("t2_no_reissue", 32'(mem_req), 32'd0);
      tick();
      check("t2_ack_count", 32'(b_ack_cnt - cnt0), 32'd1);

      // 3: A edge and b_req in the same cycle
      mem_log.delete();
      mem_bytes.push_back(8'h11);
      mem_bytes.push_back(8'h22);
      a_bank = 4'h2;
      a_addr = 20'h00ABC;
      b_addr = 24'h00BEEF;
      a_roe_n = 1'b0;
      b_req = 1'b1;
      wait_b_ack("t3_wait");
      check("t3_log_size", 32'(mem_log.size()), 32'd2);
      check("t3_first_addr", 32'(mem_log[0]), 32'h200ABC);
      check("t3_second_addr", 32'(mem_log[1]), 32'h00BEEF);
      check("t3_a_data", 32'(a_data), 32'h11);
      check("t3_b_data", 32'(b_data), 32'h22);
      b_req = 1'b0;
      a_roe_n = 1'b1;
      repeat (2) tick();

      // 4: overrun while the memory stalls
      mem_en = 1'b0;
      mem_ack = 1'b0;
      a_bank = 4'h0;
      a_addr = 20'h00005;
      a_roe_n = 1'b0;
      repeat (3) tick();
      a_roe_n = 1'b1;
      tick();
      a_addr = 20'h00006;
      a_roe_n = 1'b0;
      tick();
      check("t4_late", 32'(a_late), 32'd1);
      repeat (15) tick();
      check("t4_held_addr", 32'(mem_addr), 32'h000005);
      mem_log.delete();
      mem_bytes.push_back(8'h55);
      mem_bytes.push_back(8'h66);
      mem_en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (mem_log.size() == 2) seen = 1'b1;
      end
      check("t4_wait", 32'(seen), 32'd1);
      repeat (2) tick();
      check("t4_first_addr", 32'(mem_log[0]), 32'h000005);
      check("t4_second_addr", 32'(mem_log[1]), 32'h000006);
      check("t4_a_data", 32'(a_data), 32'h66);
      check("t4_idle", 32'(mem_req), 32'd0);
      check("t4_late_final", 32'(a_late), 32'd1);
      a_roe_n = 1'b1;
      tick();

      // 5: A edge during a B transfer is queued, not late
      mem_en = 1'b0;
      mem_ack = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("t5_late_clr", 32'(a_late), 32'd0);
      b_addr = 24'h000777;
      b_req = 1'b1;
      repeat (2) tick();
      check("t5_b_req", 32'(mem_req), 32'd1);
      check("t5_b_addr", 32'(mem_addr), 32'h000777);
      a_addr = 20'h00009;
      a_roe_n = 1'b0;
      b_req = 1'b0;
      tick();
      check("t5_late", 32'(a_late), 32'd0);
      mem_log.delete();
      mem_bytes.push_back(8'h77);
      mem_bytes.push_back(8'h99);
      mem_en = 1'b1;
      wait_b_ack("t5_wait_b");
      check("t5_b_data", 32'(b_data), 32'h77);
      check("t5_gap", 32'(mem_req), 32'd0);
      tick();
      check("t5_a_req", 32'(mem_req), 32'd1);
      check("t5_a_addr", 32'(mem_addr), 32'h000009);
      wait_mem_idle("t5_wait_a");
      check("t5_a_data", 32'(a_data), 32'h99);
      check("t5_late_final", 32'(a_late), 32'd0);
      a_roe_n = 1'b1;
      tick();

      // 6: asynchronous reset mid-A fetch, then a stray ack
      mem_en = 1'b0;
      mem_ack = 1'b0;
      a_addr = 20'h00033;
      a_roe_n = 1'b0;
      repeat (3) tick();
      check("t6_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_async_rst", 32'(mem_req), 32'd0);
      a_roe_n = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      cnt0 = b_ack_cnt;
      mem_data = 8'hFF;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      repeat (2) tick();
      check("t6_mem_req", 32'(mem_req), 32'd0);
      check("t6_mem_addr", 32'(mem_addr), 32'd0);
      check("t6_a_data", 32'(a_data), 32'd0);
      check("t6_b_data", 32'(b_data), 32'd0);
      check("t6_a_late", 32'(a_late), 32'd0);
      check("t6_no_b_ack", 32'(b_ack_cnt - cnt0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
